// File: rtl/axi_ddr_pkg.sv
// Shared definitions for the DDR-facing AXI read path: response codes,
// burst-splitting limits and the splitter FSM state type.
package axi_ddr_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // The DDR slave takes a 4-bit arlen, so 16 beats per sub-burst at most.
    localparam int AXI_MAX_SUBBURST = 16;
    localparam int AXI_4K_BYTES     = 4096;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } split_state_e;

endpackage

// File: rtl/sync_flag_fifo.sv
// Single-clock FIFO of 1-bit flags. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
// A push while full is taken only when a pop happens in the same cycle.
module sync_flag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [DEPTH-1:0] mem_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage and pointer update; the head is read before any same-slot overwrite.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_burst_splitter.sv
// AXI4 read-burst splitter in front of a DDR slave with 4-bit arlen.
// Each upstream INCR burst (8-bit arlen) is cut into sub-bursts of at most
// 16 beats; R beats pass straight through and only the final sub-burst's
// rlast is forwarded upstream, tracked by a 1-bit "last" flag FIFO.
// Build option: define AXI_SPLIT_4K_EN to also stop sub-bursts at 4 KB lines.
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; once m_arvalid rises, it and the m_ar* payload hold until accepted.
module axi_rd_burst_splitter
    import axi_ddr_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int OUTSTANDING    = 4   // power of 2, at least 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ID_WIDTH-1:0]   s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]                s_arlen,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [AXI_ID_WIDTH-1:0]   m_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [3:0]                m_arlen,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic                      rlast_err,
    output split_state_e              dbg_state_o
);

    localparam int BB      = AXI_DATA_WIDTH / 8;
    localparam int BB_LOG2 = $clog2(BB);

    split_state_e              state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]                rem_q, rem_d;
    logic                      init_q;
    logic                      err_q;
    logic [8:0]                len_w;
    logic                      last_w;
    logic                      ar_fire;
    logic                      r_last_fire;
    logic                      fifo_full, fifo_empty, fifo_head;
    logic                      fifo_push;

`ifdef AXI_SPLIT_4K_EN
    logic [12:0] bytes_to_4k;
    logic [9:0]  b4k;
    assign bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_q[11:0]};
    assign b4k         = 10'(bytes_to_4k >> BB_LOG2);
`endif

    // Sub-burst length: remaining beats capped at 16 (and at the 4 KB line when enabled).
    always_comb begin
        len_w = (rem_q < 9'(AXI_MAX_SUBBURST)) ? rem_q : 9'(AXI_MAX_SUBBURST);
`ifdef AXI_SPLIT_4K_EN
        if (b4k < 10'(len_w)) begin
            len_w = b4k[8:0];
        end
`endif
    end

    assign last_w    = (rem_q == len_w);
    assign s_arready = (state_q == ST_IDLE) && init_q;
    assign m_arvalid = (state_q == ST_ISSUE) && !fifo_full;
    assign m_arid    = id_q;
    assign m_araddr  = addr_q;
    assign m_arlen   = (state_q == ST_ISSUE) ? 4'(len_w - 9'd1) : 4'd0;
    assign ar_fire   = m_arvalid && m_arready;
    assign fifo_push = ar_fire;

    // Next-state logic: latch the request in IDLE, walk address/remaining in ISSUE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (s_arvalid && s_arready) begin
                    id_d    = s_arid;
                    addr_d  = s_araddr;
                    rem_d   = {1'b0, s_arlen} + 9'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_fire) begin
                    rem_d  = rem_q - len_w;
                    addr_d = addr_q + (AXI_ADDR_WIDTH'(len_w) << BB_LOG2);
                    if (last_w) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; init_q holds s_arready low for the reset cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            init_q  <= 1'b1;
        end
    end

    // R path: zero-latency pass-through, rlast re-formed from the flag FIFO head.
    assign s_rvalid    = m_rvalid;
    assign m_rready    = s_rready;
    assign s_rid       = m_rid;
    assign s_rdata     = m_rdata;
    assign s_rresp     = m_rresp;
    assign r_last_fire = m_rvalid && s_rready && m_rlast;
    assign s_rlast     = m_rlast && !fifo_empty && fifo_head;
    assign rlast_err   = err_q;
    assign dbg_state_o = state_q;

    // Sticky error: a sub-burst completed with nothing tracked.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (r_last_fire && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    sync_flag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_flag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push_i  (fifo_push),
        .data_i  (last_w),
        .pop_i   (r_last_fire),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Directed bench for axi_rd_burst_splitter with a small downstream slave
// model and scoreboards of expected AR sub-bursts and R beats.
module tb_axi_rd_burst_splitter;
    import axi_ddr_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int OUT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [IW-1:0] s_arid = '0;
    logic [AW-1:0] s_araddr = '0;
    logic [7:0]    s_arlen = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [IW-1:0] s_rid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast, s_rvalid;
    logic          s_rready = 1'b1;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [3:0]    m_arlen;
    logic          m_arvalid, m_arready;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast, m_rvalid, m_rready;
    logic          rlast_err;
    split_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_ar_q[$];   // {addr, arlen, id}
    logic [4:0]  exp_r_q[$];    // {id, rlast}

    // Downstream slave model controls and state
    logic          arready_en = 1'b1;
    logic          r_en = 1'b0;
    logic          manual_r = 1'b0;
    logic          man_rvalid = 1'b0;
    logic          man_rlast = 1'b0;
    logic          rsp_rvalid = 1'b0;
    logic          rsp_rlast = 1'b0;
    logic [IW-1:0] rsp_id = '0;
    logic [DW-1:0] rsp_data = '0;
    int            pend_len_q[$];
    logic [IW-1:0] pend_id_q[$];
    int            rsp_beat = 0;
    logic          ar_fire_s = 1'b0;
    logic          r_fire_s = 1'b0;
    logic [3:0]    ar_len_s = '0;
    logic [IW-1:0] ar_id_s = '0;
    int            ar_hs_cnt = 0;
    logic [DW-1:0] mon_data = '0;

    assign m_arready = arready_en;
    assign m_rvalid  = manual_r ? man_rvalid : rsp_rvalid;
    assign m_rlast   = manual_r ? man_rlast : rsp_rlast;
    assign m_rid     = rsp_id;
    assign m_rdata   = rsp_data;
    assign m_rresp   = AXI_RESP_OKAY;

    axi_rd_burst_splitter #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .OUTSTANDING    (OUT)
    ) dut (
        .aclk        (clk),
        .aresetn     (rst_n),
        .s_arid      (s_arid),
        .s_araddr    (s_araddr),
        .s_arlen     (s_arlen),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rid       (s_rid),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rlast     (s_rlast),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .m_arid      (m_arid),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rid       (m_rid),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rlast     (m_rlast),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .rlast_err   (rlast_err),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard: sample at the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [39:0] ea;
        logic [4:0]  er;
        ar_fire_s = m_arvalid && m_arready;
        ar_len_s  = m_arlen;
        ar_id_s   = m_arid;
        r_fire_s  = !manual_r && m_rvalid && s_rready;
        if (rst_n && m_arvalid && m_arready) begin
            ar_hs_cnt++;
            if (exp_ar_q.size() == 0) begin
                check("ar_unexpected", 64'(m_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ea = exp_ar_q.pop_front();
                check("ar_addr", 64'(m_araddr), 64'(ea[39:8]));
                check("ar_len", 64'(m_arlen), 64'(ea[7:4]));
                check("ar_id", 64'(m_arid), 64'(ea[3:0]));
            end
        end
        if (rst_n && !manual_r && s_rvalid && s_rready) begin
            if (exp_r_q.size() == 0) begin
                check("r_unexpected", 64'(s_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                er = exp_r_q.pop_front();
                check("r_last", 64'(s_rlast), 64'(er[0]));
                check("r_id", 64'(s_rid), 64'(er[4:1]));
                check("r_data", 64'(s_rdata), 64'(mon_data));
                check("r_resp", 64'(s_rresp), 64'(AXI_RESP_OKAY));
            end
            mon_data++;
        end
    end

    // Downstream slave model: records accepted sub-bursts, returns their beats in order
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_len_q.delete();
            pend_id_q.delete();
            rsp_beat   = 0;
            rsp_rvalid = 1'b0;
            rsp_rlast  = 1'b0;
        end else begin
            #2;
            if (ar_fire_s) begin
                pend_len_q.push_back(int'(ar_len_s) + 1);
                pend_id_q.push_back(ar_id_s);
            end
            if (r_fire_s && pend_len_q.size() != 0) begin
                rsp_data++;
                if (rsp_beat == pend_len_q[0] - 1) begin
                    void'(pend_len_q.pop_front());
                    void'(pend_id_q.pop_front());
                    rsp_beat = 0;
                end else begin
                    rsp_beat++;
                end
            end
            rsp_rvalid = 1'b0;
            rsp_rlast  = 1'b0;
            if (r_en && pend_len_q.size() != 0) begin
                rsp_rvalid = 1'b1;
                rsp_rlast  = (rsp_beat == pend_len_q[0] - 1);
                rsp_id     = pend_id_q[0];
            end
        end
    end

    task automatic push_ar(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
        exp_ar_q.push_back({addr, len, id});
    endtask

    task automatic push_r(input logic [3:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            exp_r_q.push_back({id, (i == n - 1)});
        end
    endtask

    // Called at posedge+1 with the splitter idle; returns at posedge+1 after the first issue cycle
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = len;
        s_arvalid = 1'b1;
        @(negedge clk);
        check("ar_accept_ready", 64'(s_arready), 64'd1);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        check("issue_latency", 64'(m_arvalid), 64'd1);
        check("arready_busy", 64'(s_arready), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_ar_q.size() != 0 || exp_r_q.size() != 0) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(exp_ar_q.size() + exp_r_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        // Reset
        #1 rst_n = 1'b0;
        #2;
        check("rst_s_arready", 64'(s_arready), 64'd0);
        check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_m_araddr", 64'(m_araddr), 64'd0);
        check("rst_m_arlen", 64'(m_arlen), 64'd0);
        check("rst_m_arid", 64'(m_arid), 64'd0);
        check("rst_rlast_err", 64'(rlast_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_s_arready_low", 64'(s_arready), 64'd0);
        @(negedge clk);
        check("rel_s_arready_high", 64'(s_arready), 64'd1);
        @(posedge clk);
        #1;
        r_en = 1'b1;

        // Single short burst
        push_ar(32'h100, 4'd3, 4'd1);
        push_r(4'd1, 4);
        send_ar(4'd1, 32'h100, 8'd3);
        wait_drain("drain_single", 200);

        // 40 beats split into 16/16/8
        push_ar(32'h0, 4'd15, 4'd2);
        push_ar(32'h80, 4'd15, 4'd2);
        push_ar(32'h100, 4'd7, 4'd2);
        push_r(4'd2, 40);
        send_ar(4'd2, 32'h0, 8'd39);
        wait_drain("drain_split3", 500);

        // Burst approaching a 4 KB line
`ifdef AXI_SPLIT_4K_EN
        push_ar(32'hFC0, 4'd7, 4'd3);
        push_ar(32'h1000, 4'd7, 4'd3);
`else
        push_ar(32'hFC0, 4'd15, 4'd3);
`endif
        push_r(4'd3, 16);
        send_ar(4'd3, 32'hFC0, 8'd15);
        wait_drain("drain_4k", 300);

        // m_arready stalled for 5 cycles on the second sub-burst
        base = ar_hs_cnt;
        push_ar(32'h3000, 4'd15, 4'd4);
        push_ar(32'h3080, 4'd15, 4'd4);
        push_r(4'd4, 32);
        send_ar(4'd4, 32'h3000, 8'd31);
        arready_en = 1'b0;
        check("stall_first_hs", 64'(ar_hs_cnt), 64'(base + 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(m_arvalid), 64'd1);
            check("stall_addr", 64'(m_araddr), 64'h3080);
            check("stall_len", 64'(m_arlen), 64'd15);
            check("stall_s_arready", 64'(s_arready), 64'd0);
            @(posedge clk);
            #1;
        end
        arready_en = 1'b1;
        @(negedge clk);
        check("final_hs_s_arready", 64'(s_arready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_final_s_arready", 64'(s_arready), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("drain_stall", 400);

        // Tracking FIFO full with R withheld
        r_en = 1'b0;
        base = ar_hs_cnt;
        push_ar(32'h2000, 4'd15, 4'd5);
        push_ar(32'h2080, 4'd15, 4'd5);
        push_ar(32'h2100, 4'd15, 4'd5);
        push_ar(32'h2180, 4'd15, 4'd5);
        push_r(4'd5, 64);
        send_ar(4'd5, 32'h2000, 8'd63);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_valid_low", 64'(m_arvalid), 64'd0);
            check("full_hs_count", 64'(ar_hs_cnt), 64'(base + 2));
            @(posedge clk);
            #1;
        end
        r_en = 1'b1;
        wait_drain("drain_full", 800);

        // Spurious rlast with nothing outstanding
        manual_r   = 1'b1;
        man_rvalid = 1'b1;
        man_rlast  = 1'b1;
        @(negedge clk);
        check("spur_s_rlast", 64'(s_rlast), 64'd0);
        @(posedge clk);
        #1;
        man_rvalid = 1'b0;
        man_rlast  = 1'b0;
        manual_r   = 1'b0;
        check("spur_err_set", 64'(rlast_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("spur_err_sticky", 64'(rlast_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("spur_err_cleared", 64'(rlast_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a split burst
        r_en       = 1'b0;
        arready_en = 1'b0;
        send_ar(4'd6, 32'h5000, 8'd63);
        @(negedge clk);
        check("pre_rst_state", 64'(dbg_state), 64'(ST_ISSUE));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(m_arvalid), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("midrst_s_arready", 64'(s_arready), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        arready_en = 1'b1;
        @(negedge clk);
        check("post_rst_s_arready", 64'(s_arready), 64'd1);
        check("post_rst_valid", 64'(m_arvalid), 64'd0);

        check("end_queues_empty", 64'(exp_ar_q.size() + exp_r_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
